// File: rtl/axi4_stream_downsizer_if.sv
// AXI4-Stream bundle shared by the wide (input) and narrow (output) sides of the downsizer.
// The master drives everything except tready; the slave drives tready only.
interface axi4_stream_if #(
  parameter int DATA_WIDTH = 64,
  parameter int USER_WIDTH = 1,
  parameter int DEST_WIDTH = 1,
  parameter int ID_WIDTH   = 1
) ();
  logic                    tvalid;
  logic                    tready;
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic [DATA_WIDTH/8-1:0] tstrb;
  logic                    tlast;
  logic [USER_WIDTH-1:0]   tuser;
  logic [DEST_WIDTH-1:0]   tdest;
  logic [ID_WIDTH-1:0]     tid;

  modport master (
    output tvalid, tdata, tkeep, tstrb, tlast, tuser, tdest, tid,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tkeep, tstrb, tlast, tuser, tdest, tid,
    output tready
  );
endinterface

// File: rtl/axi4_stream_downsizer.sv
// Splits each wide AXI4-Stream word into narrow slices, skipping slices with no kept bytes.
// One word is buffered; the next word loads in the same cycle its predecessor's last slice leaves.
module axi4_stream_downsizer #(
  parameter int IN_WIDTH   = 64,
  parameter int OUT_WIDTH  = 16,
  parameter int USER_WIDTH = 1,
  parameter int DEST_WIDTH = 1,
  parameter int ID_WIDTH   = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  axi4_stream_if.slave  pkt_i,
  axi4_stream_if.master pkt_o
);
  localparam int RATIO    = IN_WIDTH / OUT_WIDTH;
  localparam int IN_KEEP  = IN_WIDTH / 8;
  localparam int OUT_KEEP = OUT_WIDTH / 8;
  localparam int IDX_W    = (RATIO > 1) ? $clog2(RATIO) : 1;

  logic                  holdValid_q, holdValid_d;
  logic                  rdyEn_q, rdyEn_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [IN_WIDTH-1:0]   data_q, data_d;
  logic [IN_KEEP-1:0]    keep_q, keep_d;
  logic [IN_KEEP-1:0]    strb_q, strb_d;
  logic                  last_q, last_d;
  logic [USER_WIDTH-1:0] user_q, user_d;
  logic [DEST_WIDTH-1:0] dest_q, dest_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;

  logic [RATIO-1:0]      heldLive, inLive;
  logic                  lastSlice;
  logic [IDX_W-1:0]      nextIdx, firstIdx;
  logic [OUT_WIDTH-1:0]  sliceData;
  logic [OUT_KEEP-1:0]   sliceKeep, sliceStrb;
  logic                  inReady, inAccept, outAccept;

  always_comb begin
    heldLive = '0;
    inLive   = '0;
    for (int s = 0; s < RATIO; s++) begin
      heldLive[s] = |keep_q[s*OUT_KEEP +: OUT_KEEP];
      inLive[s]   = |pkt_i.tkeep[s*OUT_KEEP +: OUT_KEEP];
    end
  end

  // A held word with no live slices at all is a tlast-only marker; idx stays 0 and it counts as last.
  always_comb begin
    lastSlice = 1'b1;
    nextIdx   = idx_q;
    for (int s = RATIO - 1; s >= 0; s--) begin
      if (IDX_W'(s) > idx_q && heldLive[s]) begin
        lastSlice = 1'b0;
        nextIdx   = IDX_W'(s);
      end
    end
  end

  always_comb begin
    firstIdx = '0;
    for (int s = RATIO - 1; s >= 0; s--) begin
      if (inLive[s]) firstIdx = IDX_W'(s);
    end
  end

  always_comb begin
    sliceData = '0;
    sliceKeep = '0;
    sliceStrb = '0;
    for (int s = 0; s < RATIO; s++) begin
      if (IDX_W'(s) == idx_q) begin
        sliceData = data_q[s*OUT_WIDTH +: OUT_WIDTH];
        sliceKeep = keep_q[s*OUT_KEEP +: OUT_KEEP];
        sliceStrb = strb_q[s*OUT_KEEP +: OUT_KEEP];
      end
    end
  end

  assign pkt_o.tvalid = holdValid_q;
  assign pkt_o.tdata  = sliceData;
  assign pkt_o.tkeep  = sliceKeep;
  assign pkt_o.tstrb  = sliceStrb;
  assign pkt_o.tlast  = last_q && lastSlice;
  assign pkt_o.tuser  = user_q;
  assign pkt_o.tdest  = dest_q;
  assign pkt_o.tid    = id_q;

  assign inReady       = rdyEn_q && (!holdValid_q || (pkt_o.tready && lastSlice));
  assign pkt_i.tready  = inReady;
  assign inAccept      = pkt_i.tvalid && inReady;
  assign outAccept     = holdValid_q && pkt_o.tready;

  // A zero-keep word without tlast carries nothing, so it is swallowed without occupying the buffer.
  always_comb begin
    holdValid_d = holdValid_q;
    rdyEn_d     = 1'b1;
    idx_d       = idx_q;
    data_d      = data_q;
    keep_d      = keep_q;
    strb_d      = strb_q;
    last_d      = last_q;
    user_d      = user_q;
    dest_d      = dest_q;
    id_d        = id_q;
    if (inAccept) begin
      holdValid_d = (|pkt_i.tkeep) || pkt_i.tlast;
      idx_d       = firstIdx;
      data_d      = pkt_i.tdata;
      keep_d      = pkt_i.tkeep;
      strb_d      = pkt_i.tstrb;
      last_d      = pkt_i.tlast;
      user_d      = pkt_i.tuser;
      dest_d      = pkt_i.tdest;
      id_d        = pkt_i.tid;
    end else if (outAccept) begin
      if (lastSlice) holdValid_d = 1'b0;
      else           idx_d       = nextIdx;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      holdValid_q <= 1'b0;
      rdyEn_q     <= 1'b0;
      idx_q       <= '0;
      data_q      <= '0;
      keep_q      <= '0;
      strb_q      <= '0;
      last_q      <= 1'b0;
      user_q      <= '0;
      dest_q      <= '0;
      id_q        <= '0;
    end else begin
      holdValid_q <= holdValid_d;
      rdyEn_q     <= rdyEn_d;
      idx_q       <= idx_d;
      data_q      <= data_d;
      keep_q      <= keep_d;
      strb_q      <= strb_d;
      last_q      <= last_d;
      user_q      <= user_d;
      dest_q      <= dest_d;
      id_q        <= id_d;
    end
  end
endmodule

// File: tb/tb_axi4_stream_downsizer.sv
// Bench for the 32->8 downsizer: directed cases then random traffic, checked cycle by cycle
// against a queue of expected narrow beats built from each accepted wide word.
module tb_axi4_stream_downsizer;
  localparam int IW = 32;
  localparam int OW = 8;

  typedef struct packed {
    logic [7:0] data;
    logic       keep;
    logic       strb;
    logic       last;
    logic       user;
    logic       dest;
    logic       id;
  } beat_t;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  axi4_stream_if #(.DATA_WIDTH(IW)) inIf ();
  axi4_stream_if #(.DATA_WIDTH(OW)) outIf ();

  axi4_stream_downsizer #(
    .IN_WIDTH(IW), .OUT_WIDTH(OW), .USER_WIDTH(1), .DEST_WIDTH(1), .ID_WIDTH(1)
  ) dut (
    .clk_i(clk),
    .rst_i(rstN),
    .pkt_i(inIf),
    .pkt_o(outIf)
  );

  beat_t      expQ[$];
  bit         readyOk = 1'b0;
  int         readyMode = 0;
  int         patIdx = 0;
  int         checks = 0;
  int         passed = 0;

  logic        curValid = 1'b0;
  logic [31:0] curData = '0;
  logic [3:0]  curKeep = '0;
  logic [3:0]  curStrb = '0;
  logic        curLast = 1'b0;
  logic        curUser = 1'b0;
  logic        curDest = 1'b0;
  logic        curId = 1'b0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Expected narrow beats of one wide word: live slices in order, tlast on the highest one.
  task automatic pushWord(input logic [31:0] d, input logic [3:0] k, input logic [3:0] st,
                          input logic l, input logic u, input logic de, input logic i);
    beat_t b;
    int    pushed = 0;
    for (int s = 0; s < 4; s++) begin
      if (k[s]) begin
        b = '{data: d[s*8 +: 8], keep: 1'b1, strb: st[s], last: 1'b0, user: u, dest: de, id: i};
        expQ.push_back(b);
        pushed++;
      end
    end
    if (pushed > 0) begin
      b = expQ.pop_back();
      b.last = l;
      expQ.push_back(b);
    end else if (l) begin
      b = '{data: d[7:0], keep: 1'b0, strb: 1'b0, last: 1'b1, user: u, dest: de, id: i};
      expQ.push_back(b);
    end
  endtask

  task automatic applyStimulus(output bit accepted);
    beat_t head;
    logic  expValid, expReady, outRdy;
    @(negedge clk);
    case (readyMode)
      0:       outRdy = 1'b1;
      1:       outRdy = (patIdx % 4 == 0) || (patIdx % 4 == 3);
      default: outRdy = ($urandom_range(0, 9) < 7);
    endcase
    patIdx++;
    outIf.tready = outRdy;
    inIf.tvalid  = curValid;
    inIf.tdata   = curData;
    inIf.tkeep   = curKeep;
    inIf.tstrb   = curStrb;
    inIf.tlast   = curLast;
    inIf.tuser   = curUser;
    inIf.tdest   = curDest;
    inIf.tid     = curId;
    #1;
    expValid = (expQ.size() != 0);
    expReady = readyOk && (expQ.size() == 0 || (expQ.size() == 1 && outRdy));
    checkOutput("out_tvalid", 64'(outIf.tvalid), 64'(expValid));
    checkOutput("in_tready", 64'(inIf.tready), 64'(expReady));
    if (expValid) begin
      head = expQ[0];
      checkOutput("beat", 64'({outIf.tdata, outIf.tkeep, outIf.tstrb, outIf.tuser, outIf.tdest, outIf.tid}),
                  64'({head.data, head.keep, head.strb, head.user, head.dest, head.id}));
      checkOutput("out_tlast", 64'(outIf.tlast), 64'(head.last));
    end
    accepted = curValid && expReady;
    if (expValid && outRdy) void'(expQ.pop_front());
    if (accepted) pushWord(curData, curKeep, curStrb, curLast, curUser, curDest, curId);
    @(posedge clk);
    readyOk = rstN;
  endtask

  task automatic sendWord(input logic [31:0] d, input logic [3:0] k, input logic [3:0] st,
                          input logic l, input logic u, input logic de, input logic i);
    bit acc = 1'b0;
    curValid = 1'b1;
    curData = d; curKeep = k; curStrb = st; curLast = l;
    curUser = u; curDest = de; curId = i;
    for (int n = 0; n < 50 && !acc; n++) applyStimulus(acc);
    if (!acc) begin
      checks++;
      $error("[TB] FAIL accept_timeout: observed no accept expected accept within 50 cycles");
    end
    curValid = 1'b0;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int c = 0; c < n; c++) applyStimulus(acc);
  endtask

  initial begin
    bit acc;
    inIf.tvalid = 1'b0;
    outIf.tready = 1'b1;

    idle(2);
    #2 rstN = 1'b1;
    idle(2);

    readyMode = 0;
    sendWord(32'h44332211, 4'hF, 4'hF, 1'b1, 1'b1, 1'b0, 1'b1);
    idle(5);

    sendWord(32'hDDCCBBAA, 4'b1010, 4'b1000, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(3);

    sendWord(32'h87654321, 4'hF, 4'hF, 1'b0, 1'b1, 1'b1, 1'b0);
    sendWord(32'h0FEDCBA9, 4'hF, 4'h5, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(5);

    readyMode = 1;
    patIdx = 0;
    sendWord(32'h44332211, 4'hF, 4'hF, 1'b1, 1'b1, 1'b1, 1'b1);
    idle(10);

    readyMode = 0;
    sendWord(32'hCAFEF00D, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1);
    sendWord(32'h5A5A5AA5, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1);
    idle(3);

    sendWord(32'h44332211, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);
    #2 rstN = 1'b0;
    #1;
    expQ.delete();
    readyOk = 1'b0;
    checkOutput("rst_tvalid", 64'(outIf.tvalid), 64'd0);
    checkOutput("rst_tready", 64'(inIf.tready), 64'd0);
    idle(2);
    #2 rstN = 1'b1;
    idle(4);

    readyMode = 2;
    for (int w = 0; w < 60; w++) begin
      logic [3:0] k;
      k = ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      sendWord($urandom, k, k & 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) applyStimulus(acc);
    end
    idle(12);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/axi4_stream_downsizer.md
# axi4_stream_downsizer

Width converter placed directly downstream of the packet FIFO: it takes wide AXI4-Stream words from the FIFO output and re-emits them as a sequence of narrow slices for a narrower consumer. Slices whose tkeep bits are all zero are skipped, and packet boundaries (tlast) are preserved. Sideband fields are carried unchanged. The block buffers exactly one input word and adds no bubbles between consecutive words.

## Interface
Parameters:
- IN_WIDTH, 64, input tdata width in bits; multiple of 8.
- OUT_WIDTH, 16, output tdata width in bits; multiple of 8; IN_WIDTH = RATIO * OUT_WIDTH, RATIO a power of 2, ≥ 2.
- USER_WIDTH, 1, tuser width (both sides).
- DEST_WIDTH, 1, tdest width (both sides).
- ID_WIDTH, 1, tid width (both sides).

Ports:
- clk_i  input  1  single clock; all logic on rising edge.
- rst_i  input  1  reset, asynchronous, active-low.
- pkt_i  axi4_stream_if.slave  IN_WIDTH data  wide input stream (from FIFO pkt_o).
- pkt_o  axi4_stream_if.master  OUT_WIDTH data  narrow output stream.

## Operation
- RATIO = IN_WIDTH/OUT_WIDTH; slice s covers tdata[s*OUT_WIDTH +: OUT_WIDTH], tkeep/tstrb[s*OUT_WIDTH/8 +: OUT_WIDTH/8].
- State: hold_valid, holding register (full input word incl. sideband), slice index (clog2(RATIO) bits), ready-enable flag rdy_en.
- Slice s of held word is "live" if any of its tkeep bits are set. Live slices are emitted in ascending order; dead slices are skipped with no cycle spent.
- pkt_o.tdata/tkeep/tstrb = selected slice of holding register; tuser/tdest/tid = held values, repeated on every slice.
- pkt_o.tlast = held tlast AND current slice is the highest live slice.
- pkt_o.tvalid = hold_valid.
- last_slice = current slice is highest live slice. pkt_i.tready = rdy_en && (!hold_valid || (pkt_o.tready && last_slice)).
- On input accept: load holding register, hold_valid=1, slice index = lowest live slice.
- On output accept not last_slice: slice index = next live slice above current.
- On output accept of last_slice with no input accept: hold_valid=0.
- All-zero tkeep word, tlast=0: accepted, discarded; hold_valid not set; tready stays high.
- All-zero tkeep word, tlast=1: held; emits one beat from slice 0 with tkeep=0, tstrb=0, tlast=1 to keep the packet boundary.
- No modification of tdata bytes; tstrb follows tkeep slicing exactly.

## Timing
- Reset (rst_i low, async): hold_valid=0, slice index=0, rdy_en=0. So pkt_o.tvalid=0 and pkt_i.tready=0 during reset and in the first edge after release. rdy_en sets on the first rising edge after rst_i deasserts.
- Latency: word accepted at edge N → first slice valid after edge N, visible in cycle N+1.
- A word with k live slices occupies exactly k output transfers. The next input word is accepted in the same cycle as the last slice transfers, giving continuous output with no gap.
- pkt_i.tready is combinational from pkt_o.tready, by design. The FIFO upstream drives tvalid from registers, so there is no loop.
- While pkt_o.tvalid && !pkt_o.tready, all pkt_o fields are held stable.
- Reset mid-word: remaining slices are discarded immediately. Nothing from the old word is emitted after release.

## Test plan
IN_WIDTH=32, OUT_WIDTH=8, RATIO=4 unless stated.
- Full word: tdata=0x44332211, tkeep=4'hF, tlast=1, pkt_o.tready=1 → beats 0x11, 0x22, 0x33, 0x44 in cycles N+1..N+4. tlast only on 0x44. pkt_i.tready low in cycles N+1..N+3.
- Sparse keep: tdata=0xDDCCBBAA, tkeep=4'b1010, tlast=1 → two beats, 0xBB (tlast=0) then 0xDD (tlast=1), each with tkeep=1.
- Back-to-back: two tkeep=4'hF words, tlast on the second → 8 consecutive valid beats with no bubble. tlast only on beat 8. tuser/tid/tdest match the source word on each beat.
- Backpressure: pkt_o.tready toggled 1,0,0,1,… on the full-word case → data stable while stalled. Order unchanged. pkt_i.tready high only in the cycle the last slice transfers.
- Null words: tkeep=0, tlast=0 → no output beat, pkt_i.tready stays 1. tkeep=0, tlast=1 → one beat with tkeep=0, tlast=1.
- Reset mid-word: assert rst_i after 2 of 4 slices → pkt_o.tvalid drops asynchronously. After release: pkt_i.tready=0 for one cycle, then 1. No residual slices emitted.
